// File: rtl/ifid_register_pkg.sv
// Shared constants and field types for the IF/ID stage and the control unit.
// Carries the values formerly held in the shared definitions header.
package ifid_register_pkg;

    localparam int unsigned WORD      = 64;
    localparam int unsigned INSTR_LEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;
    localparam logic [10:0] OP_STUR   = 11'h7C0;
    localparam logic [7:0]  OP_CBZ8   = 8'hB4;

    typedef struct packed {
        logic [10:0] opcode;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd_rt;
        logic [4:0]  read_reg2;
    } ifid_fields_t;

endpackage

// File: rtl/ifid_register_field_split.sv
// Combinational instruction field split with the Reg2Loc select.
// Shared with the control unit.
module ifid_field_split
    import ifid_register_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [10:0] opcode_o,
    output logic [4:0]  rn_o,
    output logic [4:0]  rm_o,
    output logic [4:0]  rd_rt_o,
    output logic [4:0]  read_reg2_o
);

    logic reg2loc;

    // STUR and CBZ read their second operand from the Rt slot.
    assign reg2loc = (instr_i[31:21] == OP_STUR) || (instr_i[31:24] == OP_CBZ8);

    assign opcode_o    = instr_i[31:21];
    assign rn_o        = instr_i[9:5];
    assign rm_o        = instr_i[20:16];
    assign rd_rt_o     = instr_i[4:0];
    assign read_reg2_o = reg2loc ? instr_i[4:0] : instr_i[20:16];

endmodule

// File: rtl/ifid_register.sv
// IF/ID pipeline register with stall/flush handling, field decode and
// saturating stall/flush counters.
module ifid_register
    import ifid_register_pkg::*;
#(
    parameter int unsigned WORD      = ifid_register_pkg::WORD,
    parameter int unsigned INSTR_LEN = ifid_register_pkg::INSTR_LEN,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_LEN-1:0] if_instruction,
    input  logic [WORD-1:0]      if_cur_pc,
    input  logic [WORD-1:0]      if_incremented_pc,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 pc_write_en,
    output logic [INSTR_LEN-1:0] id_instruction,
    output logic [WORD-1:0]      id_cur_pc,
    output logic [WORD-1:0]      id_incremented_pc,
    output logic                 id_valid,
    output logic [10:0]          id_opcode,
    output logic [4:0]           id_rn,
    output logic [4:0]           id_rm,
    output logic [4:0]           id_rd_rt,
    output logic [4:0]           id_read_reg2,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    localparam logic [INSTR_LEN-1:0] NOP_W = INSTR_LEN'(NOP_INSTR);

    logic [INSTR_LEN-1:0] instr_q, instr_d;
    logic [WORD-1:0]      cur_pc_q, cur_pc_d;
    logic [WORD-1:0]      inc_pc_q, inc_pc_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [CNT_W-1:0]     flush_cnt_q;

    // A flush must still let fetch load the branch target.
    assign pc_write_en = flush | ~stall;

    always_comb begin
        instr_d  = instr_q;
        cur_pc_d = cur_pc_q;
        inc_pc_d = inc_pc_q;
        valid_d  = valid_q;
        if (flush) begin
            instr_d  = NOP_W;
            cur_pc_d = '0;
            inc_pc_d = '0;
            valid_d  = 1'b0;
        end else if (!stall) begin
            instr_d  = if_instruction;
            cur_pc_d = if_cur_pc;
            inc_pc_d = if_incremented_pc;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= NOP_W;
            cur_pc_q <= '0;
            inc_pc_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            cur_pc_q <= cur_pc_d;
            inc_pc_q <= inc_pc_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_q <= '0;
        end else if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign id_instruction    = instr_q;
    assign id_cur_pc         = cur_pc_q;
    assign id_incremented_pc = inc_pc_q;
    assign id_valid          = valid_q;
    assign stall_count       = stall_cnt_q;
    assign flush_count       = flush_cnt_q;

    ifid_field_split u_split (
        .instr_i     (instr_q[31:0]),
        .opcode_o    (id_opcode),
        .rn_o        (id_rn),
        .rm_o        (id_rm),
        .rd_rt_o     (id_rd_rt),
        .read_reg2_o (id_read_reg2)
    );

endmodule

// File: tb/tb_ifid_register.sv
// Scoreboard bench for ifid_register: directed sequence plus random traffic
// against a behavioural model, checked by an independent monitor.
module tb_ifid_register;

    localparam int unsigned CW  = 4;
    localparam int          MAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_instruction = '0;
    logic [63:0] if_cur_pc = '0;
    logic [63:0] if_incremented_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pc_write_en;
    logic [31:0] id_instruction;
    logic [63:0] id_cur_pc;
    logic [63:0] id_incremented_pc;
    logic        id_valid;
    logic [10:0] id_opcode;
    logic [4:0]  id_rn, id_rm, id_rd_rt, id_read_reg2;
    logic [CW-1:0] stall_count, flush_count;

    ifid_register #(.WORD(64), .INSTR_LEN(32), .CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_instruction    (if_instruction),
        .if_cur_pc         (if_cur_pc),
        .if_incremented_pc (if_incremented_pc),
        .stall             (stall),
        .flush             (flush),
        .pc_write_en       (pc_write_en),
        .id_instruction    (id_instruction),
        .id_cur_pc         (id_cur_pc),
        .id_incremented_pc (id_incremented_pc),
        .id_valid          (id_valid),
        .id_opcode         (id_opcode),
        .id_rn             (id_rn),
        .id_rm             (id_rm),
        .id_rd_rt          (id_rd_rt),
        .id_read_reg2      (id_read_reg2),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] cur;
        logic [63:0] inc;
        logic        valid;
        int          sc;
        int          fc;
        logic        pcwe;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // Model state after the most recent edge.
    logic [31:0] m_instr = 32'hD503201F;
    logic [63:0] m_cur = '0, m_inc = '0;
    logic        m_valid = 1'b0;
    int          m_sc = 0, m_fc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    task automatic step(input bit r, input logic [31:0] ins, input logic [63:0] pc,
                        input bit s, input bit f);
        exp_t e;
        @(negedge clk);
        reset = r;
        if_instruction = ins;
        if_cur_pc = pc;
        if_incremented_pc = pc + 64'd4;
        stall = s;
        flush = f;
        if (r) begin
            m_instr = 32'hD503201F; m_cur = '0; m_inc = '0; m_valid = 0; m_sc = 0; m_fc = 0;
        end else if (f) begin
            m_instr = 32'hD503201F; m_cur = '0; m_inc = '0; m_valid = 0;
            m_fc = (m_fc < MAX) ? m_fc + 1 : MAX;
        end else if (s) begin
            m_sc = (m_sc < MAX) ? m_sc + 1 : MAX;
        end else begin
            m_instr = ins; m_cur = pc; m_inc = pc + 64'd4; m_valid = 1;
        end
        e.instr = m_instr; e.cur = m_cur; e.inc = m_inc; e.valid = m_valid;
        e.sc = m_sc; e.fc = m_fc; e.pcwe = f | ~s;
        q.push_back(e);
    endtask

    // Monitor: compares DUT state just after each edge against the queued model.
    initial begin
        exp_t e;
        logic [4:0] r2;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                r2 = (e.instr[31:21] == 11'h7C0 || e.instr[31:24] == 8'hB4) ?
                     e.instr[4:0] : e.instr[20:16];
                chk("id_instruction", 64'(id_instruction), 64'(e.instr));
                chk("id_cur_pc", id_cur_pc, e.cur);
                chk("id_incremented_pc", id_incremented_pc, e.inc);
                chk("id_valid", 64'(id_valid), 64'(e.valid));
                chk("stall_count", 64'(stall_count), 64'(e.sc));
                chk("flush_count", 64'(flush_count), 64'(e.fc));
                chk("pc_write_en", 64'(pc_write_en), 64'(e.pcwe));
                chk("id_opcode", 64'(id_opcode), 64'(e.instr[31:21]));
                chk("id_rn", 64'(id_rn), 64'(e.instr[9:5]));
                chk("id_rm", 64'(id_rm), 64'(e.instr[20:16]));
                chk("id_rd_rt", 64'(id_rd_rt), 64'(e.instr[4:0]));
                chk("id_read_reg2", 64'(id_read_reg2), 64'(r2));
            end
        end
    end

    initial begin
        int n;
        step(1, 32'h0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0);
        step(0, 32'h91000400, 0, 0, 0);
        step(0, 32'h91000821, 4, 0, 0);
        step(0, 32'h8B020020, 8, 0, 0);
        step(0, 32'hF8000020, 12, 0, 0);
        step(0, 32'hB4000043, 16, 0, 0);
        step(0, 32'hAA0303E4, 8, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h8B050083, 64'(20 + 4 * i), 1, 0);
        step(0, 32'h8B060083, 32, 0, 0);
        step(0, 32'hF8000020, 36, 1, 1);
        step(0, 32'hB4000043, 40, 0, 0);
        for (int i = 0; i < 300; i++) begin
            n = int'($urandom_range(0, 9));
            step(($urandom_range(0, 49) == 0), $urandom, {$urandom, $urandom},
                 (n < 3), (n == 9));
        end
        step(1, 32'h0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, $urandom, 64'(4 * i), 1, 0);
        step(0, 32'h0, 0, 1, 1);
        step(1, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 1, 0);
        step(0, 32'h8B020020, 100, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
